// File: rtl/rpsc_fault_pkg.sv
// Shared constants and helpers for the RPSC fault-latch card.
package rpsc_fault_pkg;

  localparam int RPSC_MAX_CH = 32;
  localparam int RPSC_CNT_W  = 8;

  localparam logic [RPSC_MAX_CH-1:0] RPSC_HOLD_MASK_DEF = 32'h0000_00F7;
  localparam logic [RPSC_MAX_CH-1:0] RPSC_OUT_MASK_DEF  = 32'h0000_000F;

  localparam logic [RPSC_CNT_W-1:0] RPSC_CNT_MAX = '1;

  // Width of a channel index; a single-channel card still needs one bit.
  function automatic int rpsc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rpsc_fault_chan.sv
// One fault channel: two-flop synchroniser, debounce counter and state flop.
// HOLD=1 latches the state until the operator clear; HOLD=0 makes it transparent.
module rpsc_fault_chan
  import rpsc_fault_pkg::*;
#(
  parameter int DEB_CYC = 4,
  parameter bit HOLD    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic fault_in,
  output logic st,
  output logic st_nxt
);

  localparam logic [RPSC_CNT_W-1:0] DEB_LIM = RPSC_CNT_W'(DEB_CYC);

  logic [1:0]            sync;
  logic [RPSC_CNT_W-1:0] cnt;
  logic [RPSC_CNT_W-1:0] cnt_nxt;
  logic                  qual_nxt;

  // NOTE: every variable driven here gets a default first so no path can infer a latch.
  always_comb begin
    cnt_nxt = '0;
    if (sync[1]) begin
      cnt_nxt = (cnt == DEB_LIM) ? cnt : cnt + 1'b1;
    end
    qual_nxt = (cnt_nxt == DEB_LIM);
    // Set beats clear, so a still-qualified latched fault survives the clear.
    if (HOLD) begin
      st_nxt = qual_nxt | (st & ~clr);
    end else begin
      st_nxt = qual_nxt;
    end
  end

  // NOTE: state flops use non-blocking assignment so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      st   <= 1'b0;
    end else begin
      sync <= {sync[0], fault_in};
      cnt  <= cnt_nxt;
      st   <= st_nxt;
    end
  end

endmodule

// File: rtl/rpsc_fault_card.sv
// Parametrised RPSC fault-latch card: N_CH channels, masks, LA test points,
// event counter and first-fault record (built only with RPSC_FIRST_FAULT_EN).
module rpsc_fault_card
  import rpsc_fault_pkg::*;
#(
  parameter int                     N_CH      = 8,
  parameter int                     DEB_CYC   = 4,
  parameter logic [RPSC_MAX_CH-1:0] HOLD_MASK = RPSC_HOLD_MASK_DEF,
  parameter logic [RPSC_MAX_CH-1:0] OUT_MASK  = RPSC_OUT_MASK_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          reset_hold_error,
  input  logic                          LA_Test,
  input  logic [N_CH-1:0]               fault_in,
  output logic [N_CH-1:0]               out,
  output logic [N_CH-1:0]               la,
  output logic                          fault_any,
  output logic [RPSC_CNT_W-1:0]         fault_cnt,
  output logic                          ff_valid,
  output logic [rpsc_idx_w(N_CH)-1:0]   ff_idx
);

  localparam int IDX_W = rpsc_idx_w(N_CH);

  logic [N_CH-1:0]       st;
  logic [N_CH-1:0]       st_nxt;
  logic [N_CH-1:0]       st_rise;
  logic [5:0]            rise_cnt;
  logic [RPSC_CNT_W:0]   cnt_sum;
  logic [RPSC_CNT_W-1:0] fault_cnt_nxt;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    rpsc_fault_chan #(
      .DEB_CYC (DEB_CYC),
      .HOLD    (HOLD_MASK[i])
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .clr      (reset_hold_error),
      .fault_in (fault_in[i]),
      .st       (st[i]),
      .st_nxt   (st_nxt[i])
    );
  end

  assign st_rise = st_nxt & ~st;

  always_comb begin
    rise_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      rise_cnt = rise_cnt + 6'(st_rise[i]);
    end
    cnt_sum       = {1'b0, fault_cnt} + (RPSC_CNT_W + 1)'(rise_cnt);
    fault_cnt_nxt = cnt_sum[RPSC_CNT_W] ? RPSC_CNT_MAX : cnt_sum[RPSC_CNT_W-1:0];
  end

  // Outputs are registered from the next channel state so they move on the same edge as st.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      la        <= '0;
      fault_any <= 1'b0;
      fault_cnt <= '0;
    end else begin
      out       <= st_nxt & OUT_MASK[N_CH-1:0];
      la        <= st_nxt | {N_CH{LA_Test}};
      fault_any <= |st_nxt;
      fault_cnt <= fault_cnt_nxt;
    end
  end

`ifdef RPSC_FIRST_FAULT_EN
  logic [IDX_W-1:0] low_idx;

  always_comb begin
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (st_rise[i]) low_idx = IDX_W'(i);
    end
  end

  // The clear outranks a capture on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_valid <= 1'b0;
      ff_idx   <= '0;
    end else if (reset_hold_error) begin
      ff_valid <= 1'b0;
      ff_idx   <= '0;
    end else if (!ff_valid && (|st_rise)) begin
      ff_valid <= 1'b1;
      ff_idx   <= low_idx;
    end
  end
`else
  assign ff_valid = 1'b0;
  assign ff_idx   = '0;
`endif

endmodule

// File: tb/tb_rpsc_fault_card.sv
// Scoreboard bench for rpsc_fault_card with default parameters (N_CH=8, DEB_CYC=4).
module tb_rpsc_fault_card;

  localparam int N_CH  = 8;
  localparam int IDX_W = 3;
`ifdef RPSC_FIRST_FAULT_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  typedef enum int {S_OUT, S_LA, S_ANY, S_CNT, S_FFV, S_FFI} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             reset_hold_error = 1'b0;
  logic             LA_Test = 1'b0;
  logic [N_CH-1:0]  fault_in = '0;
  logic [N_CH-1:0]  out;
  logic [N_CH-1:0]  la;
  logic             fault_any;
  logic [7:0]       fault_cnt;
  logic             ff_valid;
  logic [IDX_W-1:0] ff_idx;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_cnt  = 0;

  rpsc_fault_card dut (
    .clk              (clk),
    .reset            (reset),
    .reset_hold_error (reset_hold_error),
    .LA_Test          (LA_Test),
    .fault_in         (fault_in),
    .out              (out),
    .la               (la),
    .fault_any        (fault_any),
    .fault_cnt        (fault_cnt),
    .ff_valid         (ff_valid),
    .ff_idx           (ff_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] observe(input sel_e sel);
    case (sel)
      S_OUT:   return 32'(out);
      S_LA:    return 32'(la);
      S_ANY:   return 32'(fault_any);
      S_CNT:   return 32'(fault_cnt);
      S_FFV:   return 32'(ff_valid);
      default: return 32'(ff_idx);
    endcase
  endfunction

  task automatic push(input string tag, input sel_e sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic push_ff(input string tag, input logic v, input int idx);
    push({tag, "_ffv"}, S_FFV, FF_EN ? 32'(v) : 32'd0);
    push({tag, "_ffi"}, S_FFI, FF_EN ? 32'(idx) : 32'd0);
  endtask

  task automatic push_all_zero(input string tag);
    push({tag, "_out"}, S_OUT, 0);
    push({tag, "_la"},  S_LA,  0);
    push({tag, "_any"}, S_ANY, 0);
    push({tag, "_cnt"}, S_CNT, 0);
    push_ff(tag, 1'b0, 0);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    push_all_zero(tag);
    drain();
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(1);
    apply_reset("rst_init");

    // Glitch rejection, then a qualified pulse on latched channel 0.
    fault_in[0] = 1'b1;
    tick(3);
    fault_in[0] = 1'b0;
    tick(6);
    push("glitch_out", S_OUT, 0);
    push("glitch_la",  S_LA,  0);
    push("glitch_cnt", S_CNT, 0);
    drain();
    fault_in[0] = 1'b1;
    tick(5);
    push("ch0_pre_out", S_OUT, 0);
    drain();
    tick(1);
    push("ch0_out", S_OUT, 32'h01);
    push("ch0_la",  S_LA,  32'h01);
    push("ch0_any", S_ANY, 1);
    push("ch0_cnt", S_CNT, 1);
    push_ff("ch0", 1'b1, 0);
    drain();
    tick(4);
    fault_in[0] = 1'b0;
    tick(5);
    push("ch0_hold_out", S_OUT, 32'h01);
    push("ch0_hold_cnt", S_CNT, 1);
    drain();

    // Transparent channel 3 falls two edges after the input drops.
    apply_reset("rst_ch3");
    fault_in[3] = 1'b1;
    tick(10);
    push("ch3_out", S_OUT, 32'h08);
    drain();
    fault_in[3] = 1'b0;
    tick(2);
    push("ch3_fall1_out", S_OUT, 32'h08);
    drain();
    tick(1);
    push("ch3_fall2_out", S_OUT, 0);
    push("ch3_fall2_la",  S_LA,  0);
    push("ch3_fall2_any", S_ANY, 0);
    push("ch3_cnt", S_CNT, 1);
    drain();

    // Latched channel 1: operator clear after release, then while still qualified.
    apply_reset("rst_ch1");
    fault_in[1] = 1'b1;
    tick(8);
    fault_in[1] = 1'b0;
    push("ch1_out", S_OUT, 32'h02);
    push_ff("ch1", 1'b1, 1);
    drain();
    tick(5);
    push("ch1_preclr_out", S_OUT, 32'h02);
    drain();
    reset_hold_error = 1'b1;
    tick(1);
    reset_hold_error = 1'b0;
    push("ch1_clr_out", S_OUT, 0);
    push_ff("ch1_clr", 1'b0, 0);
    drain();
    fault_in[1] = 1'b1;
    tick(6);
    push("ch1_re_out", S_OUT, 32'h02);
    push("ch1_re_cnt", S_CNT, 2);
    push_ff("ch1_re", 1'b1, 1);
    drain();
    reset_hold_error = 1'b1;
    tick(1);
    reset_hold_error = 1'b0;
    push("ch1_qclr_out", S_OUT, 32'h02);
    push("ch1_qclr_cnt", S_CNT, 2);
    push_ff("ch1_qclr", 1'b0, 0);
    drain();
    fault_in[1] = 1'b0;

    // Simultaneous rises on channels 5 and 2, then a later rise on channel 0.
    apply_reset("rst_ff");
    fault_in = 8'h24;
    tick(6);
    push("ff52_out", S_OUT, 32'h04);
    push("ff52_la",  S_LA,  32'h24);
    push("ff52_cnt", S_CNT, 2);
    push_ff("ff52", 1'b1, 2);
    drain();
    fault_in[0] = 1'b1;
    tick(6);
    push("ff0_out", S_OUT, 32'h05);
    push("ff0_cnt", S_CNT, 3);
    push_ff("ff0", 1'b1, 2);
    drain();

    // LA test mode and masked channel 4.
    fault_in = '0;
    apply_reset("rst_la");
    LA_Test = 1'b1;
    push("la_lag", S_LA, 0);
    drain();
    tick(1);
    push("la_on_la",  S_LA,  32'hFF);
    push("la_on_out", S_OUT, 0);
    drain();
    reset = 1'b1;
    #1;
    push("la_rst_la", S_LA, 0);
    drain();
    tick(1);
    reset = 1'b0;
    tick(1);
    push("la_rel_la", S_LA, 32'hFF);
    drain();
    fault_in[4] = 1'b1;
    tick(6);
    push("ch4_la",  S_LA,  32'hFF);
    push("ch4_out", S_OUT, 0);
    push("ch4_any", S_ANY, 1);
    drain();
    LA_Test = 1'b0;
    tick(1);
    push("ch4_la_off", S_LA, 32'h10);
    push("ch4_out_off", S_OUT, 0);
    drain();
    fault_in = '0;

    // Reset mid-debounce must restart the full qualification delay.
    apply_reset("rst_pre_mid");
    fault_in[0] = 1'b1;
    tick(3);
    apply_reset("rst_mid");
    tick(5);
    push("mid_pre_out", S_OUT, 0);
    drain();
    tick(1);
    push("mid_out", S_OUT, 32'h01);
    drain();
    fault_in = '0;

    // Drive fault_cnt into saturation with batches of eight rises.
    apply_reset("rst_sat");
    exp_cnt = 0;
    for (int r = 0; r < 32; r++) begin
      fault_in = '1;
      tick(6);
      exp_cnt = (exp_cnt + 8 > 255) ? 255 : exp_cnt + 8;
      push($sformatf("sat_cnt_%0d", r), S_CNT, 32'(exp_cnt));
      drain();
      fault_in = '0;
      tick(3);
      reset_hold_error = 1'b1;
      tick(1);
      reset_hold_error = 1'b0;
    end
    fault_in = 8'h07;
    tick(6);
    push("sat_plus3_cnt", S_CNT, 255);
    push("sat_plus3_out", S_OUT, 32'h07);
    drain();
    apply_reset("rst_sat_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rpsc_fault_card.md
# rpsc_fault_card

Parametrised fault-latch card for the RPSC interlock chain, succeeding the fixed eight-channel cards.
- Takes N_CH asynchronous fault inputs; each is synchronised, debounced and qualified.
- Each channel is either latched (held until an operator clear) or transparent, chosen per channel at build time.
- Drives interlock outputs and logic-analyser (LA) test-point outputs, a saturating fault-event counter and an optional first-fault record for the supervisory readback.

## Interface
- N_CH, 8: number of fault channels, 1..32
- DEB_CYC, 4: consecutive synchronised-high cycles required to qualify a fault, 1..255
- HOLD_MASK, 32'h0000_00F7: bit i = 1 makes channel i latched (hold-error); 0 makes it transparent
- OUT_MASK, 32'h0000_000F: bit i = 1 enables out[i]; a masked channel drives out[i] = 0, but its LA output still operates
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high global reset
- reset_hold_error  input  1  synchronous operator clear for latched channels and the first-fault record
- LA_Test  input  1  forces every LA output high
- fault_in  input  N_CH  raw asynchronous fault inputs, active-high
- out  output  N_CH  interlock outputs, registered
- la  output  N_CH  LA test-point outputs, registered
- fault_any  output  1  OR of all channel states, registered
- fault_cnt  output  8  saturating count of channel-rise events
- ff_valid  output  1  first-fault record valid
- ff_idx  output  $clog2(N_CH) (minimum 1)  index of the first faulting channel

## Operation
- Per channel: two-flop synchroniser, then a debounce counter.
  - Counter increments while the synchroniser output is high and saturates at DEB_CYC.
  - Counter clears to 0 on a low synchroniser output.
  - qual = (counter == DEB_CYC).
- Channel state st[i]:
  - Transparent channel: st follows qual.
  - Latched channel: st sets on qual and holds until reset_hold_error.
  - If set and clear occur on the same edge, set wins, so a still-qualified latched fault never clears.
- reset_hold_error has no effect on transparent channels or on debounce counters.
- out[i] = st[i] & OUT_MASK[i].
- la[i] = st[i] | LA_Test.
- fault_any = |st.
- fault_cnt adds the popcount of rising st bits on each edge and saturates at 255.
  - fault_cnt is cleared only by reset; reset_hold_error does not clear it.
- First-fault record:
  - When ff_valid = 0 and any st bit rises, capture the lowest rising index into ff_idx and set ff_valid.
  - Later rises are ignored until reset_hold_error.
  - A clear and a new rise on the same edge: the clear wins and the new rise is not captured.
- Reset (asynchronous, at any time including mid-debounce): every counter, synchroniser, st, out, la, fault_any, fault_cnt, ff_valid and ff_idx goes to 0.
  - la reads 0 during reset even if LA_Test is high.
  - After release, la reflects LA_Test from the first edge.

## Timing
- Rise latency: fault_in high from edge 0 on → synchroniser output high after edge 1 → qual and st high after edge DEB_CYC+1 → out, la and fault_any high after edge DEB_CYC+1.
- Fall latency, transparent channel: fault_in low at edge 0 → st, out and la low after edge 2.
- Glitch rejection: an input pulse shorter than DEB_CYC cycles produces no output.
- Clear latency: reset_hold_error high at edge n, with qual low → latched st low after edge n.
- Counters: fault_cnt updates on the same edge as st rises.
- First fault: ff_valid and ff_idx update on the same edge as the st rise.
- LA_Test: la reflects a change one edge after LA_Test changes.

## Configuration
- RPSC_FIRST_FAULT_EN defined: the first-fault record is built as described.
- RPSC_FIRST_FAULT_EN undefined: the record logic is removed and ff_valid and ff_idx are tied to 0; all other behaviour is identical.

## Structure
- Package rpsc_fault_pkg holds:
  - RPSC_MAX_CH = 32 and RPSC_CNT_W = 8;
  - the default HOLD_MASK and OUT_MASK constants;
  - the index-width function (max($clog2(N), 1)).
- Sub-module rpsc_fault_chan (parameters DEB_CYC, HOLD) contains the synchroniser, debounce counter and state flop; it is instantiated N_CH times via generate.
- The top level contains the masks, LA logic, counter and first-fault record.

## Test plan
- DEB_CYC=4; fault_in[0] high for 3 cycles, then for 10 cycles → no output from the 3-cycle pulse; out[0] and la[0] rise after edge 5 of the 10-cycle pulse; fault_cnt = 1.
- Transparent channel 3 (HOLD_MASK bit clear): fault_in[3] held 10 cycles then dropped → out[3] high, then low 2 edges after the drop.
- Latched channel 1: fault_in[1] pulsed 8 cycles and released, reset_hold_error pulsed 5 cycles later → out[1] stays high until that edge; pulse reset_hold_error again while the fault is still qualified → out[1] stays high.
- Channels 5 and 2 rise on the same edge with RPSC_FIRST_FAULT_EN defined → ff_idx = 2, ff_valid = 1, fault_cnt += 2; a later rise on channel 0 leaves ff_idx = 2.
- LA_Test = 1 with no faults → all la = 1 and out = 0; on channel 4 (OUT_MASK bit clear) a fault gives la[4] = 1 and out[4] = 0.
- Assert reset mid-debounce, and again with fault_cnt at 255 and 3 further rises → every output is 0 immediately; before the reset, fault_cnt stays saturated at 255.
